alarm_scheduler: RTL and testbench

ALARM_SCHEDULER -- requirements
Module: alarm_scheduler

---
 rtl/alarm_scheduler.sv | 152 +++++++++++++++
 tb/tb_alarm_scheduler.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/alarm_scheduler.sv
// alarm_scheduler: settable daily alarm with single-pulse trigger; optional snooze enabled by `SNOOZE_EN
module alarm_scheduler #(
    parameter int RESET_HOUR = 6,
    parameter int RESET_MIN  = 0,
    parameter int SNOOZE_MIN = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    input  logic       alarm_en,
    input  logic       btn_set,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_clear,
`ifdef SNOOZE_EN
    input  logic       btn_snooze,
`endif
    output logic       alarm,
    output logic [4:0] alarm_hour,
    output logic [5:0] alarm_min,
    output logic [1:0] edit_mode,
    output logic       ringing
);
    typedef enum logic [2:0] {
        IDLE,
        SET_HOUR,
        SET_MIN,
`ifdef SNOOZE_EN
        SNOOZE,
`endif
        RINGING
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] hour_q, hour_d;
    logic [5:0] min_q, min_d;
    logic       match_dly_q, match_dly_d;
    logic       alarm_q, alarm_d;
    logic       match, up_only, down_only;
`ifdef SNOOZE_EN
    logic [4:0] tgt_hour_q, tgt_hour_d;
    logic [5:0] tgt_min_q, tgt_min_d;
    logic       smatch_dly_q, smatch_dly_d;
    logic       smatch, carry;
    logic [6:0] snz_sum;
`endif

    assign match      = (cur_hour == hour_q) && (cur_min == min_q) && (cur_sec == 6'd0);
    assign up_only    = btn_up && !btn_down;
    assign down_only  = btn_down && !btn_up;
    assign alarm      = alarm_q;
    assign alarm_hour = hour_q;
    assign alarm_min  = min_q;
    assign ringing    = (state_q == RINGING);
    assign edit_mode  = (state_q == SET_HOUR) ? 2'b01 : (state_q == SET_MIN) ? 2'b10 : 2'b00;
`ifdef SNOOZE_EN
    assign smatch  = (cur_hour == tgt_hour_q) && (cur_min == tgt_min_q) && (cur_sec == 6'd0);
    assign snz_sum = {1'b0, cur_min} + 7'(SNOOZE_MIN);
    assign carry   = (snz_sum >= 7'd60);
`endif

    // next-state, alarm-time editing and trigger decision
    always_comb begin
        state_d     = state_q;
        hour_d      = hour_q;
        min_d       = min_q;
        alarm_d     = 1'b0;
        match_dly_d = match;
`ifdef SNOOZE_EN
        tgt_hour_d   = tgt_hour_q;
        tgt_min_d    = tgt_min_q;
        smatch_dly_d = smatch;
`endif
        case (state_q)
            IDLE: begin
                if (alarm_en && match && !match_dly_q) begin
                    alarm_d = 1'b1;
                    state_d = RINGING;
                end else if (btn_set) begin
                    state_d = SET_HOUR;
                end
            end
            SET_HOUR: begin
                if (up_only)
                    hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                else if (down_only)
                    hour_d = (hour_q == 5'd0) ? 5'd23 : hour_q - 5'd1;
                if (btn_set)
                    state_d = SET_MIN;
            end
            SET_MIN: begin
                if (up_only)
                    min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
                else if (down_only)
                    min_d = (min_q == 6'd0) ? 6'd59 : min_q - 6'd1;
                if (btn_set)
                    state_d = IDLE;
            end
            RINGING: begin
                if (btn_clear || !alarm_en) begin
                    state_d = IDLE;
`ifdef SNOOZE_EN
                end else if (btn_snooze) begin
                    state_d    = SNOOZE;
                    tgt_min_d  = carry ? 6'(snz_sum - 7'd60) : snz_sum[5:0];
                    tgt_hour_d = !carry ? cur_hour : (cur_hour == 5'd23) ? 5'd0 : cur_hour + 5'd1;
`endif
                end
            end
`ifdef SNOOZE_EN
            SNOOZE: begin
                if (btn_clear || !alarm_en) begin
                    state_d = IDLE;
                end else if (smatch && !smatch_dly_q) begin
                    alarm_d = 1'b1;
                    state_d = RINGING;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // state and alarm-time registers; match history resets high so release never triggers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            hour_q      <= 5'(RESET_HOUR);
            min_q       <= 6'(RESET_MIN);
            match_dly_q <= 1'b1;
            alarm_q     <= 1'b0;
`ifdef SNOOZE_EN
            tgt_hour_q   <= 5'd0;
            tgt_min_q    <= 6'd0;
            smatch_dly_q <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            hour_q      <= hour_d;
            min_q       <= min_d;
            match_dly_q <= match_dly_d;
            alarm_q     <= alarm_d;
`ifdef SNOOZE_EN
            tgt_hour_q   <= tgt_hour_d;
            tgt_min_q    <= tgt_min_d;
            smatch_dly_q <= smatch_dly_d;
`endif
        end
    end
endmodule

// File: tb/tb_alarm_scheduler.sv
// tb_alarm_scheduler: directed bench with a minutes-of-day reference model checked every cycle
module tb_alarm_scheduler;
    localparam int RH = 6, RM = 0, SM = 5;
    localparam int M_IDLE = 0, M_HOUR = 1, M_MIN = 2, M_RING = 3, M_SNZ = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] cur_hour;
    logic [5:0] cur_min, cur_sec;
    logic       alarm_en, btn_set, btn_up, btn_down, btn_clear;
`ifdef SNOOZE_EN
    logic       btn_snooze;
`endif
    logic       alarm, ringing;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_min;
    logic [1:0] edit_mode;

    int checks = 0, errors = 0, pulses = 0, p0;
    int m_mode, m_al, m_tgt, now_m;
    logic m_prev, m_sprev, m_pulse;
    logic match_now, smatch_now;

    alarm_scheduler #(.RESET_HOUR(RH), .RESET_MIN(RM), .SNOOZE_MIN(SM)) dut (
        .clk(clk), .reset(reset), .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
        .alarm_en(alarm_en), .btn_set(btn_set), .btn_up(btn_up), .btn_down(btn_down),
        .btn_clear(btn_clear),
`ifdef SNOOZE_EN
        .btn_snooze(btn_snooze),
`endif
        .alarm(alarm), .alarm_hour(alarm_hour), .alarm_min(alarm_min),
        .edit_mode(edit_mode), .ringing(ringing)
    );

    always #5 clk = ~clk;

    always_comb begin
        now_m      = int'(cur_hour) * 60 + int'(cur_min);
        match_now  = (cur_sec == 6'd0) && (now_m == m_al);
        smatch_now = (cur_sec == 6'd0) && (now_m == m_tgt);
    end

    // reference model: alarm time and snooze target kept as minutes of the day
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_mode <= M_IDLE; m_al <= RH * 60 + RM; m_tgt <= 0;
            m_prev <= 1'b1; m_sprev <= 1'b1; m_pulse <= 1'b0;
        end else begin
            m_prev <= match_now; m_sprev <= smatch_now; m_pulse <= 1'b0;
            if (m_mode == M_IDLE) begin
                if (alarm_en && match_now && !m_prev) begin m_pulse <= 1'b1; m_mode <= M_RING; end
                else if (btn_set) m_mode <= M_HOUR;
            end else if (m_mode == M_HOUR) begin
                if (btn_up != btn_down) m_al <= ((m_al / 60 + (btn_up ? 1 : 23)) % 24) * 60 + m_al % 60;
                if (btn_set) m_mode <= M_MIN;
            end else if (m_mode == M_MIN) begin
                if (btn_up != btn_down) m_al <= (m_al / 60) * 60 + (m_al % 60 + (btn_up ? 1 : 59)) % 60;
                if (btn_set) m_mode <= M_IDLE;
            end else if (m_mode == M_RING) begin
                if (btn_clear || !alarm_en) m_mode <= M_IDLE;
`ifdef SNOOZE_EN
                else if (btn_snooze) begin m_tgt <= (now_m + SM) % 1440; m_mode <= M_SNZ; end
`endif
            end else begin
                if (btn_clear || !alarm_en) m_mode <= M_IDLE;
                else if (smatch_now && !m_sprev) begin m_pulse <= 1'b1; m_mode <= M_RING; end
            end
        end
    end

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endtask

    // every-cycle comparison against the model
    always @(negedge clk) begin
        if (alarm) pulses++;
        chk("alarm", int'(alarm), int'(m_pulse));
        chk("ringing", int'(ringing), int'(m_mode == M_RING));
        chk("edit_mode", int'(edit_mode), m_mode == M_HOUR ? 1 : m_mode == M_MIN ? 2 : 0);
        chk("alarm_hour", int'(alarm_hour), m_al / 60);
        chk("alarm_min", int'(alarm_min), m_al % 60);
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask
    task automatic tm(input int h, input int m, input int s);
        cur_hour = 5'(h); cur_min = 6'(m); cur_sec = 6'(s);
    endtask
    task automatic set_b(input int n);
        repeat (n) begin btn_set = 1'b1; step(1); btn_set = 1'b0; end
    endtask
    task automatic up(input int n);
        repeat (n) begin btn_up = 1'b1; step(1); btn_up = 1'b0; end
    endtask
    task automatic down(input int n);
        repeat (n) begin btn_down = 1'b1; step(1); btn_down = 1'b0; end
    endtask
    task automatic clr();
        btn_clear = 1'b1; step(1); btn_clear = 1'b0;
    endtask

    initial begin
        reset = 1'b0; alarm_en = 1'b1; tm(6, 0, 0);
        btn_set = 0; btn_up = 0; btn_down = 0; btn_clear = 0;
`ifdef SNOOZE_EN
        btn_snooze = 0;
`endif
        step(3);
        chk("rst_hour", int'(alarm_hour), 6);
        chk("rst_min", int'(alarm_min), 0);
        chk("rst_edit", int'(edit_mode), 0);
        chk("rst_ring", int'(ringing), 0);
        // release at a matching time must stay silent; a fresh 06:00:00 edge rings
        reset = 1'b1; p0 = pulses; step(3);
        chk("release_no_pulse", pulses - p0, 0);
        tm(6, 1, 0); step(2); tm(6, 0, 0); step(3);
        chk("newday_pulse", pulses - p0, 1);
        chk("newday_ring", int'(ringing), 1);
        clr();
        chk("clear_ring", int'(ringing), 0);
        // edit wrap-around
        set_b(1);
        chk("edit_hour_mode", int'(edit_mode), 1);
        down(6);
        chk("hour_zero", int'(alarm_hour), 0);
        down(1);
        chk("hour_wrap_23", int'(alarm_hour), 23);
        btn_up = 1; btn_down = 1; step(1); btn_up = 0; btn_down = 0;
        chk("updown_same", int'(alarm_hour), 23);
        set_b(1);
        chk("edit_min_mode", int'(edit_mode), 2);
        down(1);
        chk("min_wrap_59", int'(alarm_min), 59);
        up(1);
        chk("min_wrap_0", int'(alarm_min), 0);
        chk("hour_kept", int'(alarm_hour), 23);
        set_b(1);
        chk("edit_exit", int'(edit_mode), 0);
        // 07:30 held for 100 cycles rings once
        set_b(1); up(8); set_b(1); up(30); set_b(1);
        chk("set_0730_h", int'(alarm_hour), 7);
        chk("set_0730_m", int'(alarm_min), 30);
        tm(7, 29, 59); step(2); tm(7, 30, 0); p0 = pulses; step(100);
        chk("hold_one_pulse", pulses - p0, 1);
        chk("hold_ring", int'(ringing), 1);
        clr(); step(5);
        chk("hold_cleared", int'(ringing), 0);
        chk("no_retrigger", pulses - p0, 1);
        // match edge during edit, then leaving edit while matching
        p0 = pulses; set_b(1); tm(7, 31, 0); step(2); tm(7, 30, 0); step(2); set_b(2); step(3);
        chk("edit_no_trigger", pulses - p0, 0);
        // disabled alarm, then enable drop while ringing
        alarm_en = 0; tm(7, 31, 0); step(2); tm(7, 30, 0); p0 = pulses; step(3);
        chk("disabled_no_pulse", pulses - p0, 0);
        alarm_en = 1; step(3);
        chk("enable_held_no_pulse", pulses - p0, 0);
        tm(7, 31, 0); step(2); tm(7, 30, 0); step(3);
        chk("reenabled_pulse", pulses - p0, 1);
        alarm_en = 0; step(1);
        chk("en_drop_ring", int'(ringing), 0);
        alarm_en = 1;
        // reset in the middle of minute editing
        tm(12, 0, 0); set_b(2); up(3);
        chk("pre_reset_min", int'(alarm_min), 33);
        #2 reset = 1'b0; #1;
        chk("async_hour", int'(alarm_hour), 6);
        chk("async_min", int'(alarm_min), 0);
        chk("async_edit", int'(edit_mode), 0);
        step(2); reset = 1'b1; step(2);
        chk("post_reset_edit", int'(edit_mode), 0);
`ifdef SNOOZE_EN
        // snooze across midnight: 23:58 + 5 -> 00:03
        set_b(1); down(7); set_b(1); down(2); set_b(1);
        chk("set_2358_h", int'(alarm_hour), 23);
        chk("set_2358_m", int'(alarm_min), 58);
        tm(23, 57, 0); step(2); tm(23, 58, 0); p0 = pulses; step(3);
        chk("ring_2358", pulses - p0, 1);
        btn_snooze = 1; step(1); btn_snooze = 0;
        chk("snooze_ring_off", int'(ringing), 0);
        tm(23, 59, 0); step(2); tm(0, 2, 0); step(2); tm(0, 3, 0); step(3);
        chk("snooze_pulse", pulses - p0, 2);
        chk("snooze_ring_on", int'(ringing), 1);
        btn_clear = 1; btn_snooze = 1; step(1); btn_clear = 0; btn_snooze = 0;
        chk("clear_wins_ring", int'(ringing), 0);
        tm(0, 2, 0); step(2); tm(0, 3, 0); step(3);
        chk("clear_wins_no_snooze", pulses - p0, 2);
`endif
        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
